decode_stage: RTL
=================

# decode_stage

Registered instruction-decode pipeline stage for the 32-bit core, sitting between fetch and execute. It splits each instruction word into register indices, function code and sign-extended immediate, and produces the full control-bit set. It adds what the combinational decoder lacked: a valid/ready handshake on both sides, a pipeline flush, illegal-opcode flagging and a parametrised load-use interlock that inserts bubbles.

## Interface
Reset is synchronous and active-low.

Parameters:
- XLEN, 32, width of the sign-extended immediate output.
- LU_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 0..3, where 0 disables the interlock.
- ILLEGAL_AS_NOP, 1, when 1 an illegal opcode issues with every write or branch control bit cleared.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- in_valid  in  1  fetch presents an instruction word.
- in_ready  out  1  the stage accepts the word this cycle.
- in_inst  in  32  instruction word.
- flush  in  1  kills the held instruction and any pending interlock.
- out_valid  out  1  the decoded instruction is valid.
- out_ready  in  1  execute accepts the instruction.
- opcode, func, rd, rs1, rs2  out  4 each  decoded fields.
- imm  out  XLEN  sign-extended in_inst[23:8].
- ctrl_br, ctrl_jal, ctrl_mem_read, ctrl_mem_reg, ctrl_alu_op, ctrl_mem_write, ctrl_alu_src, ctrl_reg_write  out  1 each  control bits.
- illegal  out  1  the opcode is not in the set below.

## Operation
- Opcodes are shared constants: ALUR=0, CMPR=2, SW=5, BRANCH=6, ALUI=8, LW=9, CMPI=10, JAL=11. Every other value is illegal.
- Bit fields: A=[31:28], B=[27:24], C=[23:20], func=[7:4], opcode=[3:0].
- Register mapping:
  - ALUR and CMPR: rd=A, rs1=B, rs2=C.
  - ALUI, CMPI, LW and JAL: rd=A, rs1=B.
  - SW: rs1=B, rs2=A.
  - BRANCH: rs1=A, rs2=B.
  - Any index an instruction does not use is driven to 0.
- Control bits:
  - ctrl_reg_write: ALUR, ALUI, CMPR, CMPI, LW, JAL.
  - ctrl_alu_src=1 (immediate operand): ALUI, CMPI, LW, SW, JAL.
  - ctrl_alu_op=1 (compare): CMPR, CMPI, BRANCH.
  - ctrl_mem_read and ctrl_mem_reg: LW.
  - ctrl_mem_write: SW.
  - ctrl_br: BRANCH.
  - ctrl_jal: JAL.
- Illegal opcode:
  - illegal=1.
  - If ILLEGAL_AS_NOP=1, reg_write, mem_write, br and jal are forced to 0.
  - The instruction still issues, and the fields are still decoded.
- Handshake:
  - in_ready = !stall && (!out_valid || out_ready).
  - A word is captured on an edge where in_valid && in_ready.
  - out_valid holds, and the outputs stay stable, while out_valid && !out_ready.
- Load-use interlock:
  - The stage tracks the rd of the most recently issued LW whose rd is non-zero.
  - A hazard exists when the incoming word reads rs1 or rs2 and that index equals the tracked rd.
  - On a hazard the stage asserts stall for LU_BUBBLES cycles during which execute can accept.
  - During the stall, out_valid=0 is issued (bubbles) and in_ready=0.
  - The word is then captured.
  - The bubble counter decrements only on cycles where the output slot drains.
  - Issuing any non-LW instruction clears the tracking register.
- Flush:
  - Takes priority over everything else.
  - On the next edge: out_valid=0, bubble counter=0, tracking cleared.
  - in_ready=0 during the flush cycle, so no word is captured.

## Timing
- Latency is 1 cycle from the accept edge to out_valid.
- Throughput is one instruction per cycle when there is no hazard and out_ready=1.
- Reset values: out_valid=0, all ctrl_* bits 0, illegal=0, all fields 0, imm=0, bubble counter 0, tracking invalid.
- in_ready follows the reset state, so it is 1 in the first cycle after reset.
- Reset asserted mid-stall or mid-backpressure returns the stage to the reset state on that edge; nothing is retained.
- Simultaneous flush and in_valid: the word is dropped.
- Simultaneous flush and out_ready: the held instruction is considered consumed and is not reissued.
- Back-to-back LW to the same rd: the second LW reads its rs1 (B); if B equals the tracked rd, it stalls like any other consumer.
- rd=0 never creates a hazard.

## Structure
- Shared package holds:
  - the opcode constants;
  - the field bit positions;
  - a packed control-bundle typedef covering the eight ctrl bits and illegal.
- One combinational sub-module, inst_decode, maps a word to fields, control bundle and register-use flags.
- decode_stage contains the output register, the handshake, the bubble counter and the load-use tracker.

## Test plan
- ALUR with A=3, B=1, C=2, after reset, with out_ready=1 → one cycle later rd=3, rs1=1, rs2=2, reg_write=1, alu_src=0, out_valid=1.
- ALUI with imm=0xFFF0 → imm=0xFFFFFFF0 (XLEN=32), alu_src=1.
- LW with rd=5, then ALUR with rs1=5, LU_BUBBLES=1 → exactly 1 bubble cycle (out_valid=0, in_ready=0) before the ALUR issues; with LU_BUBBLES=0 there is no bubble.
- Opcode 0xF with ILLEGAL_AS_NOP=1 → illegal=1; reg_write, mem_write, br and jal all 0.
- out_ready held low for 3 cycles with in_valid=1 → outputs stable, in_ready=0, no word lost or duplicated after release.
- Flush during a load-use stall → next cycle out_valid=0 and counter cleared; the following ALUR that reads the load rd issues with no bubble.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcode map, instruction field positions and the
// packed control bundle passed from the decoder to the stage register.
package decode_stage_pkg;

  localparam logic [3:0] OP_ALUR   = 4'd0;
  localparam logic [3:0] OP_CMPR   = 4'd2;
  localparam logic [3:0] OP_SW     = 4'd5;
  localparam logic [3:0] OP_BRANCH = 4'd6;
  localparam logic [3:0] OP_ALUI   = 4'd8;
  localparam logic [3:0] OP_LW     = 4'd9;
  localparam logic [3:0] OP_CMPI   = 4'd10;
  localparam logic [3:0] OP_JAL    = 4'd11;

  localparam int A_LSB    = 28;
  localparam int B_LSB    = 24;
  localparam int C_LSB    = 20;
  localparam int IMM_LSB  = 8;
  localparam int IMM_W    = 16;
  localparam int FUNC_LSB = 4;
  localparam int OP_LSB   = 0;

  typedef struct packed {
    logic br;
    logic jal;
    logic mem_read;
    logic mem_reg;
    logic alu_op;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_inst_decode.sv
// Combinational instruction decoder: fields, sign-extended immediate,
// control bundle and which register indices the instruction actually reads.
module inst_decode
  import decode_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [3:0]      opcode,
  output logic [3:0]      func,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [XLEN-1:0] imm,
  output ctrl_t           ctrl,
  output logic            use_rs1,
  output logic            use_rs2,
  output logic            is_lw
);

  logic [3:0]       fa, fb, fc;
  logic [IMM_W-1:0] imm_raw;

  assign fa      = inst[A_LSB +: 4];
  assign fb      = inst[B_LSB +: 4];
  assign fc      = inst[C_LSB +: 4];
  assign imm_raw = inst[IMM_LSB +: IMM_W];
  assign func    = inst[FUNC_LSB +: 4];
  assign opcode  = inst[OP_LSB +: 4];
  assign imm     = XLEN'($signed(imm_raw));
  assign is_lw   = (opcode == OP_LW);

  always_comb begin
    ctrl    = '0;
    rd      = '0;
    rs1     = '0;
    rs2     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_ALUR, OP_CMPR: begin
        rd = fa; rs1 = fb; rs2 = fc;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = (opcode == OP_CMPR);
      end
      OP_ALUI, OP_CMPI, OP_LW, OP_JAL: begin
        rd = fa; rs1 = fb;
        use_rs1 = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = (opcode == OP_CMPI);
        ctrl.mem_read  = (opcode == OP_LW);
        ctrl.mem_reg   = (opcode == OP_LW);
        ctrl.jal       = (opcode == OP_JAL);
      end
      OP_SW: begin
        rs1 = fb; rs2 = fa;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        rs1 = fa; rs2 = fb;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        ctrl.alu_op = 1'b1;
        ctrl.br     = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Illegal words still flow down the pipe; make sure they cannot commit state.
    if (ctrl.illegal && ILLEGAL_AS_NOP) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.br        = 1'b0;
      ctrl.jal       = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready on both sides, flush, and a load-use
// interlock that holds off the consumer of a just-issued LW for LU_BUBBLES slots.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int LU_BUBBLES     = 1,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      opcode,
  output logic [3:0]      func,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            ctrl_br,
  output logic            ctrl_jal,
  output logic            ctrl_mem_read,
  output logic            ctrl_mem_reg,
  output logic            ctrl_alu_op,
  output logic            ctrl_mem_write,
  output logic            ctrl_alu_src,
  output logic            ctrl_reg_write,
  output logic            illegal
);

  logic [3:0]      d_opcode, d_func, d_rd, d_rs1, d_rs2;
  logic [XLEN-1:0] d_imm;
  ctrl_t           d_ctrl, ctrl_q;
  logic            d_use_rs1, d_use_rs2, d_is_lw;
  logic            lu_vld;
  logic [3:0]      lu_rd;
  logic [1:0]      bub_cnt, bub_eff;
  logic            hazard, stall, drain, accept;

  inst_decode #(.XLEN(XLEN), .ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) u_dec (
    .inst(in_inst), .opcode(d_opcode), .func(d_func), .rd(d_rd), .rs1(d_rs1),
    .rs2(d_rs2), .imm(d_imm), .ctrl(d_ctrl), .use_rs1(d_use_rs1),
    .use_rs2(d_use_rs2), .is_lw(d_is_lw)
  );

  assign hazard = (LU_BUBBLES != 0) && in_valid && lu_vld &&
                  ((d_use_rs1 && d_rs1 == lu_rd) || (d_use_rs2 && d_rs2 == lu_rd));
  // The first hazard cycle already counts as a stall slot, so the counter is
  // seeded combinationally and only its remainder is carried in bub_cnt.
  assign bub_eff  = (bub_cnt != 2'd0) ? bub_cnt : (hazard ? 2'(LU_BUBBLES) : 2'd0);
  assign stall    = (bub_eff != 2'd0);
  assign drain    = !out_valid || out_ready;
  assign in_ready = !flush && !stall && drain;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      opcode    <= '0;
      func      <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      bub_cnt   <= 2'd0;
      lu_vld    <= 1'b0;
      lu_rd     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      bub_cnt   <= 2'd0;
      lu_vld    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        ctrl_q    <= d_ctrl;
        opcode    <= d_opcode;
        func      <= d_func;
        rd        <= d_rd;
        rs1       <= d_rs1;
        rs2       <= d_rs2;
        imm       <= d_imm;
        lu_vld    <= d_is_lw && (d_rd != 4'd0);
        lu_rd     <= d_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Once a hazard is being served the tracker is spent; the counter alone holds the stall.
      if (stall) begin
        bub_cnt <= drain ? bub_eff - 2'd1 : bub_eff;
        lu_vld  <= 1'b0;
      end
    end
  end

  assign ctrl_br        = ctrl_q.br;
  assign ctrl_jal       = ctrl_q.jal;
  assign ctrl_mem_read  = ctrl_q.mem_read;
  assign ctrl_mem_reg   = ctrl_q.mem_reg;
  assign ctrl_alu_op    = ctrl_q.alu_op;
  assign ctrl_mem_write = ctrl_q.mem_write;
  assign ctrl_alu_src   = ctrl_q.alu_src;
  assign ctrl_reg_write = ctrl_q.reg_write;
  assign illegal        = ctrl_q.illegal;

endmodule
